// File: rtl/pll_std_sequencer_if.sv
// Control/status bundle between the standard sequencer and the dot4x PLL clock generator.
// The sequencer uses the slave modport; whoever drives the request, handshake and lock uses master.
interface pll_std_sequencer_if;
    logic STD_REQ;
    logic SRDY;
    logic LOCKED;
    logic SSTEP;
    logic STATE;
    logic CLK_RST;
    logic CUR_STD;
    logic BUSY;
    logic FAIL;

    modport master (
        output STD_REQ, SRDY, LOCKED,
        input  SSTEP, STATE, CLK_RST, CUR_STD, BUSY, FAIL
    );

    modport slave (
        input  STD_REQ, SRDY, LOCKED,
        output SSTEP, STATE, CLK_RST, CUR_STD, BUSY, FAIL
    );
endinterface

// File: rtl/pll_std_sequencer.sv
// Sequences NTSC/PAL reconfiguration of the dot4x PLL: step pulse, SRDY wait, lock settle, timeout/retry.
// All outputs registered and derived from the next state, so they track the state register exactly.
module pll_std_sequencer #(
    parameter int LOCK_TIMEOUT  = 2000000,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               CLKIN,
    input  logic               RST,
    pll_std_sequencer_if.slave bus
);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(LOCK_TIMEOUT);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(SETTLE_CYCLES);
    localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRIES);

    localparam logic [2:0] S_SETTLE    = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_STEP      = 3'd2;
    localparam logic [2:0] S_WAIT_SRDY = 3'd3;
    localparam logic [2:0] S_RETRY     = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    logic [2:0]      state_q,   state_d;
    logic [TO_W-1:0] to_cnt_q,  to_cnt_d;
    logic [ST_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [RT_W-1:0] retry_q,   retry_d;
    logic            target_q,  target_d;
    logic            cur_std_q, cur_std_d;
    logic            sstep_q,   sstep_d;
    logic            sel_q,     sel_d;
    logic            clk_rst_q, clk_rst_d;
    logic            busy_q,    busy_d;
    logic            fail_q,    fail_d;

    logic [TO_W-1:0] to_inc;
    logic [ST_W-1:0] stab_inc;

    // Saturating increments: counters park at their limit instead of wrapping.
    assign to_inc   = (to_cnt_q == TO_MAX)   ? to_cnt_q   : to_cnt_q + TO_W'(1);
    assign stab_inc = (stab_cnt_q == ST_MAX) ? stab_cnt_q : stab_cnt_q + ST_W'(1);

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        stab_cnt_d = stab_cnt_q;
        retry_d    = retry_q;
        target_d   = target_q;
        cur_std_d  = cur_std_q;

        case (state_q)
            S_SETTLE: begin
                to_cnt_d   = to_inc;
                stab_cnt_d = bus.LOCKED ? stab_inc : '0;
                if (bus.LOCKED && (stab_inc == ST_MAX)) begin
                    state_d    = S_IDLE;
                    retry_d    = '0;
                    to_cnt_d   = '0;
                    stab_cnt_d = '0;
                end else if (to_inc == TO_MAX) begin
                    state_d = S_RETRY;
                end
            end
            S_IDLE: begin
                to_cnt_d   = '0;
                stab_cnt_d = '0;
                // Lock loss wins over a pending request: re-validate before stepping.
                if (!bus.LOCKED) begin
                    state_d = S_SETTLE;
                end else if (bus.STD_REQ != cur_std_q) begin
                    target_d = bus.STD_REQ;
                    state_d  = S_STEP;
                end
            end
            S_STEP: begin
                to_cnt_d   = '0;
                stab_cnt_d = '0;
                state_d    = S_WAIT_SRDY;
            end
            S_WAIT_SRDY: begin
                to_cnt_d = to_inc;
                if (bus.SRDY) begin
                    state_d    = S_SETTLE;
                    to_cnt_d   = '0;
                    stab_cnt_d = '0;
                    cur_std_d  = target_q;
                end else if (to_inc == TO_MAX) begin
                    state_d = S_RETRY;
                end
            end
            S_RETRY: begin
                to_cnt_d   = '0;
                stab_cnt_d = '0;
                if (retry_q < RT_MAX) begin
                    retry_d = retry_q + RT_W'(1);
                    state_d = S_STEP;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_SETTLE;
            end
        endcase
    end

    always_comb begin
        sstep_d   = (state_d == S_STEP);
        sel_d     = (state_d == S_STEP) ? target_d : sel_q;
        clk_rst_d = (state_d != S_IDLE);
        busy_d    = (state_d != S_IDLE) && (state_d != S_FAIL);
        fail_d    = (state_d == S_FAIL);
    end

    // Reset state mirrors a PLL that powers up in PAL and has not yet proven lock.
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            state_q    <= S_SETTLE;
            to_cnt_q   <= '0;
            stab_cnt_q <= '0;
            retry_q    <= '0;
            target_q   <= 1'b1;
            cur_std_q  <= 1'b1;
            sstep_q    <= 1'b0;
            sel_q      <= 1'b1;
            clk_rst_q  <= 1'b1;
            busy_q     <= 1'b1;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            retry_q    <= retry_d;
            target_q   <= target_d;
            cur_std_q  <= cur_std_d;
            sstep_q    <= sstep_d;
            sel_q      <= sel_d;
            clk_rst_q  <= clk_rst_d;
            busy_q     <= busy_d;
            fail_q     <= fail_d;
        end
    end

    assign bus.SSTEP   = sstep_q;
    assign bus.STATE   = sel_q;
    assign bus.CLK_RST = clk_rst_q;
    assign bus.CUR_STD = cur_std_q;
    assign bus.BUSY    = busy_q;
    assign bus.FAIL    = fail_q;
endmodule

// File: tb/tb_pll_std_sequencer.sv
// Directed bench for pll_std_sequencer: stimulus pushes expected step/snapshot records, a monitor pops and compares.
module tb_pll_std_sequencer;
    localparam int LT = 100;
    localparam int SC = 8;
    localparam int MR = 2;

    logic CLKIN = 1'b0;
    logic RST   = 1'b1;
    int   cyc   = 0;

    pll_std_sequencer_if bus();

    pll_std_sequencer #(
        .LOCK_TIMEOUT (LT),
        .SETTLE_CYCLES(SC),
        .MAX_RETRIES  (MR)
    ) dut (
        .CLKIN(CLKIN),
        .RST  (RST),
        .bus  (bus)
    );

    always #5 CLKIN = ~CLKIN;
    always @(posedge CLKIN) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [5:0] v;
    } snap_t;

    snap_t snap_q[$];
    logic  exp_step_q[$];
    int    step_cyc_q[$];
    int    checks = 0;
    int    errors = 0;
    int    low_cnt = 0;
    logic  prev_sstep = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output vector order: {SSTEP, STATE, CLK_RST, CUR_STD, BUSY, FAIL}
    function automatic logic [5:0] outs();
        return {bus.SSTEP, bus.STATE, bus.CLK_RST, bus.CUR_STD, bus.BUSY, bus.FAIL};
    endfunction

    initial begin
        snap_t s;
        logic  e;
        forever begin
            @(negedge CLKIN);
            if (bus.CLK_RST === 1'b0) low_cnt++;
            if (bus.SSTEP === 1'b1) begin
                check("sstep_spacing", 32'(prev_sstep), 32'd0);
                check("sstep_expected", 32'(exp_step_q.size() > 0), 32'd1);
                if (exp_step_q.size() > 0) begin
                    e = exp_step_q.pop_front();
                    check("sstep_state_sel", 32'(bus.STATE), 32'(e));
                    step_cyc_q.push_back(cyc);
                end
            end
            prev_sstep = (bus.SSTEP === 1'b1);
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                check(s.name, 32'(outs()), 32'(s.v));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLKIN);
        #1;
    endtask

    task automatic expect_snap(input string name, input logic [5:0] v);
        snap_t s;
        s.name = name;
        s.v    = v;
        snap_q.push_back(s);
    endtask

    task automatic wait_fall(input string name, input int exp_n);
        int n;
        n = 0;
        while (bus.CLK_RST !== 1'b0 && n < 40) begin
            tick(1);
            n++;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        int c0;
        int n;
        bus.STD_REQ = 1'b1;
        bus.SRDY    = 1'b0;
        bus.LOCKED  = 1'b0;
        RST         = 1'b1;

        // Power-up settle in PAL
        tick(2);
        expect_snap("reset_outs", 6'b011110);
        tick(1);
        RST = 1'b0;
        c0  = cyc;
        tick(10);
        expect_snap("powerup_settling", 6'b011110);
        tick(10);
        bus.LOCKED = 1'b1;
        n = 0;
        while (bus.CLK_RST !== 1'b0 && n < 60) begin
            tick(1);
            n++;
        end
        check("powerup_clk_rst_fall_window", 32'((cyc - c0) >= 27 && (cyc - c0) <= 29), 32'd1);
        expect_snap("powerup_idle", 6'b010100);
        tick(2);

        // PAL -> NTSC
        bus.STD_REQ = 1'b0;
        exp_step_q.push_back(1'b0);
        tick(1);
        expect_snap("ntsc_step", 6'b101110);
        bus.LOCKED = 1'b0;
        low_cnt = 0;
        tick(10);
        bus.SRDY = 1'b1;
        tick(1);
        bus.SRDY = 1'b0;
        expect_snap("ntsc_after_srdy", 6'b001010);
        tick(3);
        bus.LOCKED = 1'b1;
        wait_fall("ntsc_settle_cycles", SC);
        check("ntsc_clk_rst_continuous", 32'(low_cnt), 32'd0);
        expect_snap("ntsc_idle", 6'b000000);
        tick(3);

        // Lock loss in IDLE
        bus.LOCKED = 1'b0;
        tick(1);
        expect_snap("lockloss_clk_rst", 6'b001010);
        tick(2);
        bus.LOCKED = 1'b1;
        wait_fall("lockloss_resettle", SC);
        expect_snap("lockloss_idle", 6'b000000);
        tick(3);

        // NTSC -> PAL with request toggled back during WAIT_SRDY
        bus.STD_REQ = 1'b1;
        exp_step_q.push_back(1'b1);
        tick(1);
        bus.LOCKED = 1'b0;
        tick(5);
        bus.STD_REQ = 1'b0;
        tick(5);
        bus.SRDY = 1'b1;
        tick(1);
        bus.SRDY = 1'b0;
        expect_snap("toggle_first_done", 6'b011110);
        exp_step_q.push_back(1'b0);
        tick(2);
        bus.LOCKED = 1'b1;
        wait_fall("toggle_first_settle", SC);
        expect_snap("toggle_idle_pal", 6'b010100);
        tick(1);
        expect_snap("toggle_second_step", 6'b101110);
        bus.LOCKED = 1'b0;
        tick(2);
        bus.SRDY = 1'b1;
        tick(1);
        bus.SRDY = 1'b0;
        tick(1);
        bus.LOCKED = 1'b1;
        wait_fall("toggle_second_settle", SC);
        expect_snap("toggle_idle_ntsc", 6'b000000);
        tick(3);

        // SRDY withheld: three tries then FAIL
        step_cyc_q.delete();
        bus.STD_REQ = 1'b1;
        repeat (3) exp_step_q.push_back(1'b1);
        c0 = cyc;
        tick(1);
        bus.LOCKED = 1'b0;
        n = 0;
        while (bus.FAIL !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check("fail_entry_cycle", 32'(cyc - c0), 32'd307);
        check("fail_step_count", 32'(step_cyc_q.size()), 32'd3);
        if (step_cyc_q.size() == 3) begin
            check("fail_gap_1", 32'(step_cyc_q[1] - step_cyc_q[0]), 32'd102);
            check("fail_gap_2", 32'(step_cyc_q[2] - step_cyc_q[1]), 32'd102);
        end
        expect_snap("fail_outs", 6'b011001);
        tick(2);
        bus.STD_REQ = 1'b0;
        bus.LOCKED  = 1'b1;
        tick(5);
        bus.STD_REQ = 1'b1;
        bus.SRDY    = 1'b1;
        tick(5);
        bus.STD_REQ = 1'b0;
        bus.SRDY    = 1'b0;
        tick(5);
        expect_snap("fail_sticky", 6'b011001);
        tick(2);

        // RST clears FAIL, then RST during lock wait
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        bus.STD_REQ = 1'b1;
        bus.LOCKED  = 1'b1;
        wait_fall("rst_recover_settle", SC);
        expect_snap("rst_recover_idle", 6'b010100);
        tick(2);
        bus.STD_REQ = 1'b0;
        exp_step_q.push_back(1'b0);
        tick(1);
        bus.LOCKED = 1'b0;
        tick(3);
        bus.SRDY = 1'b1;
        tick(1);
        bus.SRDY = 1'b0;
        expect_snap("pre_rst_wait_lock", 6'b001010);
        tick(2);
        RST = 1'b1;
        tick(1);
        expect_snap("rst_mid_wait_lock", 6'b011110);
        RST = 1'b0;
        bus.STD_REQ = 1'b1;
        bus.LOCKED  = 1'b1;
        wait_fall("rst_restart_settle", SC);
        expect_snap("rst_restart_idle", 6'b010100);
        tick(3);

        check("pending_steps", 32'(exp_step_q.size()), 32'd0);
        check("pending_snaps", 32'(snap_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/pll_std_sequencer.md
Name: pll_std_sequencer

Overview:
- Control stage directly upstream of the dot4x PLL clock generator. Runs on the 50 MHz board clock.
- Turns a video-standard request (0=NTSC, 1=PAL) into the generator's one-cycle reconfigure pulse and state select.
- Waits for the reconfigure-ready handshake and a stable PLL lock, with timeout and retry.
- Holds the dot4x clock domain in reset whenever the PLL output is not trustworthy.

Parameters:
- LOCK_TIMEOUT, 2000000: max CLKIN cycles allowed in WAIT_SRDY or WAIT_LOCK before a try is declared failed.
- SETTLE_CYCLES, 64: consecutive LOCKED=1 cycles required before the PLL is declared stable.
- MAX_RETRIES, 3: re-steps allowed after the first failed try before entering FAIL.

Ports:
- CLKIN  in  1  50 MHz board clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- STD_REQ  in  1  requested standard (0=NTSC, 1=PAL); already synchronous to CLKIN.
- SRDY  in  1  reconfigure-done handshake from the clock generator.
- LOCKED  in  1  PLL lock from the clock generator.
- SSTEP  out  1  one-cycle reconfigure pulse to the clock generator.
- STATE  out  1  standard select to the clock generator.
- CLK_RST  out  1  reset for the dot4x domain; 1 while the PLL is not stable.
- CUR_STD  out  1  standard the PLL is currently configured and locked for.
- BUSY  out  1  1 in every state except IDLE and FAIL.
- FAIL  out  1  sticky failure flag; cleared only by RST.

Behaviour:
- Reset values: SSTEP=0, STATE=1, CLK_RST=1, CUR_STD=1, BUSY=1, FAIL=0, state=SETTLE, counters=0, retry=0.
- Reset values reflect the PLL powering up in PAL.
- All outputs are registered.
- State SETTLE:
  - stab_cnt increments while LOCKED=1 and clears to 0 when LOCKED=0.
  - to_cnt increments every cycle.
  - stab_cnt reaching SETTLE_CYCLES -> IDLE; CLK_RST drops on the IDLE entry cycle.
  - to_cnt reaching LOCK_TIMEOUT -> RETRY.
- State IDLE:
  - CLK_RST=0, BUSY=0.
  - LOCKED=0 takes priority: CLK_RST=1 next cycle, go to SETTLE with no re-step (lock loss).
  - Otherwise, if STD_REQ != CUR_STD: latch target=STD_REQ and go to STEP.
- State STEP (exactly 1 cycle):
  - SSTEP=1 and STATE=target; CLK_RST=1 from this cycle.
  - Then go to WAIT_SRDY with to_cnt=0.
- STATE is held at target from STEP until the next STEP. It never changes mid-handshake.
- State WAIT_SRDY:
  - SRDY=1 -> SETTLE with counters cleared, and CUR_STD=target.
  - to_cnt reaching LOCK_TIMEOUT -> RETRY.
  - SRDY=1 seen in the same cycle as the timeout counts as success.
- State RETRY (1 cycle):
  - retry < MAX_RETRIES: retry+1, then go to STEP with the same target.
  - Otherwise go to FAIL.
  - retry clears to 0 on every IDLE entry.
- State FAIL: CLK_RST=1, FAIL=1, BUSY=0; inputs are ignored until RST.
- STD_REQ changes while busy are not latched. After returning to IDLE, the mismatch check fires again, so a request toggled mid-sequence is honoured afterwards.
- A request returning to CUR_STD before IDLE causes no extra step.
- An SRDY pulse arriving outside WAIT_SRDY is ignored.
- SSTEP is never asserted on two consecutive cycles. Minimum spacing between steps is 3 cycles.
- RST asserted mid-operation: return to reset values on the next edge. SSTEP drops immediately. The partially completed generator sequence is not aborted; SETTLE re-validates lock.
- Counter widths are clog2(LOCK_TIMEOUT+1) and clog2(SETTLE_CYCLES+1). Counters saturate and never wrap.

Test Plan:
Bench parameters: LOCK_TIMEOUT=100, SETTLE_CYCLES=8, MAX_RETRIES=2.
- Power-up, STD_REQ=1, LOCKED rises at cycle 20 -> CLK_RST falls at cycle 28±1, SSTEP never pulses, CUR_STD=1, BUSY=0.
- From IDLE(PAL), set STD_REQ=0 -> one SSTEP pulse with STATE=0. Drive SRDY 10 cycles later, then LOCKED for 8 cycles -> CUR_STD=0, CLK_RST=0. CLK_RST stays high continuously from the step until stability.
- Withhold SRDY permanently -> exactly 3 SSTEP pulses spaced about 102 cycles apart, then FAIL=1, CLK_RST=1, BUSY=0. Further STD_REQ toggles produce no pulses until RST.
- In IDLE, drop LOCKED for 3 cycles -> CLK_RST=1 within 1 cycle, no SSTEP. CLK_RST returns to 0 after 8 stable lock cycles.
- Toggle STD_REQ 1->0 during WAIT_SRDY of a 0->1 change (start from NTSC) -> first sequence completes with CUR_STD=1, then a second SSTEP with STATE=0 follows.
- Assert RST during WAIT_LOCK -> next cycle all outputs at reset values and the state machine restarts in SETTLE.
